stopwatch_ctrl: RTL

Sequencing controller for the stopwatch datapath: it turns single-cycle debounced button pulses into run, pause, stop, clear and recall control of the time counter. It also owns the lap register bank and selects the value shown on the seven-segment display. It sits between the button debouncers and the counter/display, and replaces ad-hoc control inside the counter.

---
 rtl/stopwatch_ctrl_if.sv | 36 +++
 rtl/stopwatch_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Bundles the button pulses, recall address, live time and the controller outputs
// so the stopwatch controller and its neighbours share one port.
interface stopwatch_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int TIME_W = 24
);
  logic              start_stop_p;
  logic              pause_resume_p;
  logic              record_recall_p;
  logic              recall_mode_p;
  logic [ADDR_W-1:0] reg_address;
  logic [TIME_W-1:0] time_in;
  logic              count_en;
  logic              count_clr;
  logic [TIME_W-1:0] disp_time;
  logic [ADDR_W:0]   lap_count;
  logic              lap_overflow;
  logic              reg_exceed;
  logic              started_led;
  logic              paused_led;
  logic              recall_led;

  modport master (
    output start_stop_p, pause_resume_p, record_recall_p, recall_mode_p,
    output reg_address, time_in,
    input  count_en, count_clr, disp_time, lap_count, lap_overflow,
    input  reg_exceed, started_led, paused_led, recall_led
  );

  modport slave (
    input  start_stop_p, pause_resume_p, record_recall_p, recall_mode_p,
    input  reg_address, time_in,
    output count_en, count_clr, disp_time, lap_count, lap_overflow,
    output reg_exceed, started_led, paused_led, recall_led
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: turns debounced button pulses into counter
// run/clear control, owns the lap register bank and picks the displayed time.
module stopwatch_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int TIME_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_STOP,
    S_RECALL
  } state_t;

  state_t            r_state, w_stateNxt;
  state_t            r_retState, w_retStateNxt;
  logic [ADDR_W-1:0] r_rdPtr, w_rdPtrNxt;
  logic [ADDR_W:0]   r_lapCount, w_lapCountNxt;
  logic              r_lapOverflow, w_lapOverflowNxt;
  logic              w_lapWrite;
  logic              w_countClrNxt;
  logic              w_regExceedNxt;

  logic              w_ss, w_pr, w_rr, w_rm;
  logic              w_full, w_hasLaps, w_stepWrap;

  logic [TIME_W-1:0] r_lap [DEPTH];

  logic              r_countEn, r_countClr, r_regExceed;
  logic              r_startedLed, r_pausedLed, r_recallLed;
  logic [TIME_W-1:0] r_dispTime;

  // Only the highest-priority pulse of a cycle survives; the rest are dropped.
  assign w_ss = bus.start_stop_p;
  assign w_pr = bus.pause_resume_p & ~w_ss;
  assign w_rr = bus.record_recall_p & ~w_ss & ~bus.pause_resume_p;
  assign w_rm = bus.recall_mode_p & ~w_ss & ~bus.pause_resume_p & ~bus.record_recall_p;

  assign w_full     = (r_lapCount == (ADDR_W+1)'(DEPTH));
  assign w_hasLaps  = (r_lapCount != '0);
  // Stepping from the last valid entry or from an empty one both land on 0.
  assign w_stepWrap = (({1'b0, r_rdPtr} + (ADDR_W+1)'(1)) >= r_lapCount);

  always_comb begin
    w_stateNxt       = r_state;
    w_retStateNxt    = r_retState;
    w_rdPtrNxt       = r_rdPtr;
    w_lapCountNxt    = r_lapCount;
    w_lapOverflowNxt = r_lapOverflow;
    w_lapWrite       = 1'b0;
    w_countClrNxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_ss) begin
          w_stateNxt = S_RUN;
        end else if (w_rm && w_hasLaps) begin
          w_stateNxt    = S_RECALL;
          w_retStateNxt = S_IDLE;
          w_rdPtrNxt    = bus.reg_address;
        end
      end
      S_RUN: begin
        if (w_ss)      w_stateNxt = S_STOP;
        else if (w_pr) w_stateNxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_ss)      w_stateNxt = S_STOP;
        else if (w_pr) w_stateNxt = S_RUN;
      end
      S_STOP: begin
        if (w_ss) begin
          w_stateNxt       = S_RUN;
          w_countClrNxt    = 1'b1;
          w_lapCountNxt    = '0;
          w_lapOverflowNxt = 1'b0;
        end else if (w_rm && w_hasLaps) begin
          w_stateNxt    = S_RECALL;
          w_retStateNxt = S_STOP;
          w_rdPtrNxt    = bus.reg_address;
        end
      end
      S_RECALL: begin
        if (w_rr) begin
          w_rdPtrNxt = w_stepWrap ? '0 : r_rdPtr + ADDR_W'(1);
        end else if (w_rm) begin
          w_stateNxt = r_retState;
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase

    if ((r_state == S_RUN || r_state == S_PAUSE) && w_rr) begin
      if (w_full) begin
        w_lapOverflowNxt = 1'b1;
      end else begin
        w_lapWrite    = 1'b1;
        w_lapCountNxt = r_lapCount + (ADDR_W+1)'(1);
      end
    end

    w_regExceedNxt = (w_stateNxt == S_RECALL) && ({1'b0, w_rdPtrNxt} >= w_lapCountNxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_retState    <= S_IDLE;
      r_rdPtr       <= '0;
      r_lapCount    <= '0;
      r_lapOverflow <= 1'b0;
      r_countEn     <= 1'b0;
      r_countClr    <= 1'b0;
      r_regExceed   <= 1'b0;
      r_startedLed  <= 1'b0;
      r_pausedLed   <= 1'b0;
      r_recallLed   <= 1'b0;
      r_dispTime    <= '0;
    end else begin
      r_state       <= w_stateNxt;
      r_retState    <= w_retStateNxt;
      r_rdPtr       <= w_rdPtrNxt;
      r_lapCount    <= w_lapCountNxt;
      r_lapOverflow <= w_lapOverflowNxt;
      r_countEn     <= (w_stateNxt == S_RUN);
      r_countClr    <= w_countClrNxt;
      r_regExceed   <= w_regExceedNxt;
      r_startedLed  <= (w_stateNxt == S_RUN) || (w_stateNxt == S_PAUSE);
      r_pausedLed   <= (w_stateNxt == S_PAUSE);
      r_recallLed   <= (w_stateNxt == S_RECALL);
      // Display follows the state already in effect, hence one extra cycle of latency.
      if (r_state == S_RECALL) begin
        r_dispTime <= r_regExceed ? '0 : r_lap[r_rdPtr];
      end else begin
        r_dispTime <= bus.time_in;
      end
    end
  end

  // Lap bank is deliberately unreset; entries past lap_count are never shown.
  always_ff @(posedge clk) begin
    if (w_lapWrite) begin
      r_lap[r_lapCount[ADDR_W-1:0]] <= bus.time_in;
    end
  end

  assign bus.count_en     = r_countEn;
  assign bus.count_clr    = r_countClr;
  assign bus.disp_time    = r_dispTime;
  assign bus.lap_count    = r_lapCount;
  assign bus.lap_overflow = r_lapOverflow;
  assign bus.reg_exceed   = r_regExceed;
  assign bus.started_led  = r_startedLed;
  assign bus.paused_led   = r_pausedLed;
  assign bus.recall_led   = r_recallLed;

endmodule
